updown_counter_ctrl: RTL and testbench

- Parametrised up/down display counter with two debounced push-button controls: direction toggle and run/pause toggle.
- Selectable slow/fast count rate; synchronous parallel load; configurable modulus.
- Sits between board buttons/switches and LED/seven-segment output logic.
- Generalises the fixed 4-bit single-button up/down counter to any width, modulus and rate.

---
 rtl/updown_counter_ctrl_if.sv | 39 +++
 rtl/updown_counter_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_updown_counter_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/updown_counter_ctrl_if.sv
// updown_counter_ctrl_if: control and display signals of updown_counter_ctrl.
// The board side (buttons, switches, load) is the master; the counter is the slave.
// With UPDOWN_COUNTER_SATURATE_EN defined the at_limit status signal is added.
interface updown_counter_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             hz;
    logic             btn_dir;
    logic             btn_run;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] out;
    logic             dir;
    logic             running;
    logic             step;
`ifdef UPDOWN_COUNTER_SATURATE_EN
    logic             at_limit;

    modport master (
        output hz, btn_dir, btn_run, load, load_val,
        input  out, dir, running, step, at_limit
    );

    modport slave (
        input  hz, btn_dir, btn_run, load, load_val,
        output out, dir, running, step, at_limit
    );
`else
    modport master (
        output hz, btn_dir, btn_run, load, load_val,
        input  out, dir, running, step
    );

    modport slave (
        input  hz, btn_dir, btn_run, load, load_val,
        output out, dir, running, step
    );
`endif
endinterface

// File: rtl/updown_counter_ctrl.sv
// updown_counter_ctrl: up/down display counter for buttons/switches -> LEDs.
// Two debounced push buttons toggle count direction and run/pause. The count
// rate comes from a prescaler whose period is picked by hz, load forces a
// clamped value, and the count wraps between 0 and MAX_VAL.
// Optional macro UPDOWN_COUNTER_SATURATE_EN: count saturates at 0 / MAX_VAL
// instead of wrapping, saturated ticks give no step pulse, and at_limit is added.
// The raw buttons are sampled only on the debounce strobe; the shift register
// is the sampling stage, so buttons are expected to be slow board signals.
module updown_counter_ctrl #(
    parameter int WIDTH      = 4,
    parameter int MAX_VAL    = 15,
    parameter int SLOW_DIV   = 25000000,
    parameter int FAST_DIV   = 250000,
    parameter int DB_TICK    = 75000,
    parameter int DB_SAMPLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    updown_counter_ctrl_if.slave bus
);
    localparam int DIV_MAX = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int PW      = $clog2(DIV_MAX);
    localparam int DBW     = (DB_TICK > 1) ? $clog2(DB_TICK) : 1;
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

    logic [DBW-1:0]        db_cnt;
    logic                  db_strobe;
    logic [DB_SAMPLES-1:0] sh_dir, sh_run;
    logic [DB_SAMPLES-1:0] sh_dir_nxt, sh_run_nxt;
    logic                  lvl_dir, lvl_run;
    logic                  lvl_dir_d, lvl_run_d;
    logic                  press_dir, press_run;

    logic [PW-1:0]         presc;
    logic [PW-1:0]         div_last;
    logic                  hz_q;
    logic                  hz_chg;
    logic                  presc_end;
    logic                  tick;

    logic [WIDTH-1:0]      out_q, out_nxt;
    logic [WIDTH-1:0]      load_clamp;
    logic                  dir_q, dir_nxt;
    logic                  run_q;
    logic                  step_q, step_nxt;

    assign db_strobe  = (db_cnt == DBW'(DB_TICK - 1));
    assign sh_dir_nxt = {sh_dir[DB_SAMPLES-2:0], bus.btn_dir};
    assign sh_run_nxt = {sh_run[DB_SAMPLES-2:0], bus.btn_run};

    // Press pulses only on the rising edge of a debounced level.
    assign press_dir  = lvl_dir & ~lvl_dir_d;
    assign press_run  = lvl_run & ~lvl_run_d;

    assign hz_chg     = bus.hz ^ hz_q;
    assign div_last   = bus.hz ? PW'(FAST_DIV - 1) : PW'(SLOW_DIV - 1);
    assign presc_end  = (presc == div_last);
    // A rate change restarts the period, so it may not also emit a tick.
    assign tick       = run_q & ~hz_chg & presc_end;

    assign load_clamp = (bus.load_val > MAXV) ? MAXV : bus.load_val;
    assign dir_nxt    = dir_q ^ press_dir;

    // Free-running debounce sample timer, strobes once every DB_TICK cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt <= '0;
        end else if (db_strobe) begin
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DBW'(1);
        end
    end

    // Sample both buttons; a level only moves after DB_SAMPLES equal samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_dir  <= '0;
            sh_run  <= '0;
            lvl_dir <= 1'b0;
            lvl_run <= 1'b0;
        end else if (db_strobe) begin
            sh_dir <= sh_dir_nxt;
            sh_run <= sh_run_nxt;
            if (&sh_dir_nxt) begin
                lvl_dir <= 1'b1;
            end else if (~|sh_dir_nxt) begin
                lvl_dir <= 1'b0;
            end
            if (&sh_run_nxt) begin
                lvl_run <= 1'b1;
            end else if (~|sh_run_nxt) begin
                lvl_run <= 1'b0;
            end
        end
    end

    // Delayed debounced levels for press-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl_dir_d <= 1'b0;
            lvl_run_d <= 1'b0;
        end else begin
            lvl_dir_d <= lvl_dir;
            lvl_run_d <= lvl_run;
        end
    end

    // Rate prescaler: cleared by load or rate change, frozen while paused.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            hz_q  <= 1'b0;
        end else begin
            hz_q <= bus.hz;
            if (bus.load || hz_chg) begin
                presc <= '0;
            end else if (run_q) begin
                presc <= presc_end ? '0 : presc + PW'(1);
            end
        end
    end

    // Next count: load wins over tick; a tick uses the direction held before any toggle.
    always_comb begin
        out_nxt  = out_q;
        step_nxt = 1'b0;
        if (bus.load) begin
            out_nxt = load_clamp;
        end else if (tick) begin
            step_nxt = 1'b1;
            if (!dir_q) begin
                if (out_q != MAXV) begin
                    out_nxt = out_q + WIDTH'(1);
                end else begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
                    step_nxt = 1'b0;
`else
                    out_nxt = '0;
`endif
                end
            end else begin
                if (out_q != '0) begin
                    out_nxt = out_q - WIDTH'(1);
                end else begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
                    step_nxt = 1'b0;
`else
                    out_nxt = MAXV;
`endif
                end
            end
        end
    end

    // Registered outputs: counter, direction, run state and step pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q  <= '0;
            dir_q  <= 1'b0;
            run_q  <= 1'b1;
            step_q <= 1'b0;
        end else begin
            out_q  <= out_nxt;
            dir_q  <= dir_nxt;
            run_q  <= run_q ^ press_run;
            step_q <= step_nxt;
        end
    end

`ifdef UPDOWN_COUNTER_SATURATE_EN
    logic at_limit_q;

    // Limit flag tracks the next out/dir so it lines up with the registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            at_limit_q <= 1'b0;
        end else begin
            at_limit_q <= ((out_nxt == MAXV) && !dir_nxt) || ((out_nxt == '0) && dir_nxt);
        end
    end

    assign bus.at_limit = at_limit_q;
`endif

    assign bus.out     = out_q;
    assign bus.dir     = dir_q;
    assign bus.running = run_q;
    assign bus.step    = step_q;
endmodule

// File: tb/tb_updown_counter_ctrl.sv
// tb_updown_counter_ctrl: scoreboard bench for updown_counter_ctrl.
// A reference model advanced once per clock pushes each expected count step
// (edge index, value, direction) into a queue; an independent monitor pops on
// every step pulse and flags late, early, missing or unexpected steps.
module tb_updown_counter_ctrl;
    localparam int WIDTH      = 4;
    localparam int MAX_VAL    = 9;
    localparam int SLOW_DIV   = 10;
    localparam int FAST_DIV   = 4;
    localparam int DB_TICK    = 2;
    localparam int DB_SAMPLES = 4;
`ifdef UPDOWN_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        int cyc;
        int val;
        int dir;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   ecnt;
    int   steps_seen = 0;
    exp_t sbq[$];

    // Reference model state
    int   m_out, m_dir, m_run, m_phase, m_hzq, m_k;
    int   db_last[2];
    int   db_len[2];
    int   lvl[2];
    int   lvl_d[2];

    always #5 clk = ~clk;

    updown_counter_ctrl_if #(.WIDTH(WIDTH)) bus ();

    updown_counter_ctrl #(
        .WIDTH(WIDTH), .MAX_VAL(MAX_VAL), .SLOW_DIV(SLOW_DIV),
        .FAST_DIV(FAST_DIV), .DB_TICK(DB_TICK), .DB_SAMPLES(DB_SAMPLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always @(posedge clk or negedge rst) begin
        if (!rst) ecnt <= 0;
        else      ecnt <= ecnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_out = 0; m_dir = 0; m_run = 1; m_phase = 0; m_hzq = 0; m_k = 0;
        for (int i = 0; i < 2; i++) begin
            db_last[i] = 0;
            db_len[i]  = DB_SAMPLES;
            lvl[i]     = 0;
            lvl_d[i]   = 0;
        end
        sbq.delete();
    endfunction

    function automatic bit will_tick();
        int div;
        div = bus.hz ? FAST_DIV : SLOW_DIV;
        return (m_run == 1) && (int'(bus.hz) == m_hzq) && (m_phase == div - 1);
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    function automatic void model_step();
        int   press[2];
        int   smp[2];
        int   div, nxt, new_dir;
        bit   tick;
        exp_t e;
        for (int i = 0; i < 2; i++) press[i] = (lvl[i] == 1 && lvl_d[i] == 0) ? 1 : 0;
        div     = bus.hz ? FAST_DIV : SLOW_DIV;
        tick    = will_tick();
        new_dir = m_dir ^ press[0];
        if (bus.load) begin
            m_out   = (int'(bus.load_val) > MAX_VAL) ? MAX_VAL : int'(bus.load_val);
            m_phase = 0;
        end else if (tick) begin
            if (SAT) nxt = (m_dir == 0) ? ((m_out < MAX_VAL) ? m_out + 1 : MAX_VAL)
                                        : ((m_out > 0) ? m_out - 1 : 0);
            else     nxt = (m_dir == 0) ? (m_out + 1) % (MAX_VAL + 1)
                                        : (m_out + MAX_VAL) % (MAX_VAL + 1);
            if (nxt != m_out) begin
                e.cyc = m_k; e.val = nxt; e.dir = new_dir;
                sbq.push_back(e);
            end
            m_out   = nxt;
            m_phase = 0;
        end else if (int'(bus.hz) != m_hzq) begin
            m_phase = 0;
        end else if (m_run == 1) begin
            m_phase++;
        end
        m_dir = new_dir;
        m_run = m_run ^ press[1];
        smp[0] = int'(bus.btn_dir);
        smp[1] = int'(bus.btn_run);
        for (int i = 0; i < 2; i++) begin
            lvl_d[i] = lvl[i];
            if (m_k % DB_TICK == DB_TICK - 1) begin
                if (smp[i] == db_last[i]) db_len[i]++;
                else begin db_last[i] = smp[i]; db_len[i] = 1; end
                if (db_len[i] >= DB_SAMPLES) lvl[i] = smp[i];
            end
        end
        m_hzq = int'(bus.hz);
        m_k++;
    endfunction

    task automatic run(input int n);
        repeat (n) begin
            model_step();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_out"}, int'(bus.out), m_out);
        check({tag, "_dir"}, int'(bus.dir), m_dir);
        check({tag, "_running"}, int'(bus.running), m_run);
`ifdef UPDOWN_COUNTER_SATURATE_EN
        check({tag, "_at_limit"}, int'(bus.at_limit),
              ((m_out == MAX_VAL && m_dir == 0) || (m_out == 0 && m_dir == 1)) ? 1 : 0);
`endif
    endtask

    task automatic wait_for_tick(input string tag);
        int n;
        n = 0;
        while (!will_tick() && n < 30) begin
            run(1);
            n++;
        end
        check({tag, "_tick_wait"}, (n < 30) ? 1 : 0, 1);
    endtask

    // Monitor: consume one expected step per step pulse, flag stray or missed pulses.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bus.step) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_step", int'(bus.step), 0);
                    end else begin
                        e = sbq.pop_front();
                        steps_seen++;
                        check("step_cycle", ecnt, e.cyc + 1);
                        check("step_out", int'(bus.out), e.val);
                        check("step_dir", int'(bus.dir), e.dir);
                    end
                end else if (sbq.size() > 0 && sbq[0].cyc + 1 <= ecnt) begin
                    e = sbq.pop_front();
                    check("missing_step", int'(bus.step), 1);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int s0, len;
        bus.hz = 1'b0; bus.btn_dir = 1'b0; bus.btn_run = 1'b0;
        bus.load = 1'b0; bus.load_val = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", int'(bus.out), 0);
        check("rst_dir", int'(bus.dir), 0);
        check("rst_running", int'(bus.running), 1);
        check("rst_step", int'(bus.step), 0);
        rst = 1'b1;

        // Slow rate: ten ticks in 100 cycles, wrapping 9 -> 0.
        s0 = steps_seen;
        run(101);
        check("slow_steps", steps_seen - s0, SAT ? 9 : 10);
        check("slow_out", int'(bus.out), SAT ? 9 : 0);
        check_state("slow");

        // Glitchy direction press: exactly one toggle.
        bus.btn_dir = 1'b1; run(1);
        bus.btn_dir = 1'b0; run(1);
        bus.btn_dir = 1'b1; run(1);
        bus.btn_dir = 1'b0; run(1);
        bus.btn_dir = 1'b1; run(12);
        bus.btn_dir = 1'b0; run(14);
        check("glitch_dir", int'(bus.dir), 1);
        check_state("glitch");

        // Counting down from 0 wraps to MAX_VAL.
        bus.load = 1'b1; bus.load_val = '0; run(1);
        bus.load = 1'b0; run(10);
        check("down_wrap_out", int'(bus.out), SAT ? 0 : 9);
        check("down_wrap_step", int'(bus.step), SAT ? 0 : 1);

        // Short pulse is rejected.
        bus.btn_dir = 1'b1; run(3);
        bus.btn_dir = 1'b0; run(14);
        check("short_dir", int'(bus.dir), 1);

        // Pause, stay frozen, then resume from the remaining prescaler count.
        bus.btn_run = 1'b1; run(12);
        bus.btn_run = 1'b0; run(14);
        check("pause_running", int'(bus.running), 0);
        s0 = steps_seen;
        run(50);
        check("pause_steps", steps_seen - s0, 0);
        check_state("pause");
        bus.btn_run = 1'b1; run(12);
        bus.btn_run = 1'b0; run(14);
        check("resume_running", int'(bus.running), 1);
        check_state("resume");

        // Load coinciding with a tick: clamped, no step, full period to next tick.
        wait_for_tick("load");
        bus.load = 1'b1; bus.load_val = 4'd12; run(1);
        bus.load = 1'b0;
        check("load_out", int'(bus.out), 9);
        check("load_step", int'(bus.step), 0);
        run(9);
        check("load_early_step", int'(bus.step), 0);
        run(1);
        check("load_next_step", int'(bus.step), 1);
        check("load_next_out", int'(bus.out), 8);

        // Rate change on a would-be tick: suppressed, next tick after FAST_DIV cycles.
        wait_for_tick("hz");
        bus.hz = 1'b1; run(1);
        check("hz_chg_step", int'(bus.step), 0);
        run(3);
        check("hz_wait_step", int'(bus.step), 0);
        run(1);
        check("hz_fast_step", int'(bus.step), 1);
        check_state("hz");

        // Randomised buttons, loads and rate changes.
        for (int seg = 0; seg < 60; seg++) begin
            len = $urandom_range(1, 12);
            bus.btn_dir = 1'($urandom_range(0, 1));
            bus.btn_run = 1'($urandom_range(0, 1));
            for (int c = 0; c < len; c++) begin
                bus.load     = ($urandom_range(0, 19) == 0);
                bus.load_val = WIDTH'($urandom_range(0, 15));
                if ($urandom_range(0, 39) == 0) bus.hz = ~bus.hz;
                run(1);
            end
            check_state("rand");
        end
        bus.btn_dir = 1'b0; bus.btn_run = 1'b0; bus.load = 1'b0;
        run(14);
        check_state("settle");

        // Asynchronous reset in the middle of a clock period.
        bus.load = 1'b1; bus.load_val = 4'd5; run(1);
        bus.load = 1'b0; run(3);
        #6;
        rst = 1'b0;
        #1;
        check("async_out", int'(bus.out), 0);
        check("async_dir", int'(bus.dir), 0);
        check("async_running", int'(bus.running), 1);
        check("async_step", int'(bus.step), 0);
        model_reset();
        @(posedge clk);
        #1;
        bus.hz = 1'b0;
        rst = 1'b1;
        run(30);
        check_state("post_rst");
        run(2);
        check("queue_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
